act_led_stretch: RTL
====================

// Module: act_led_stretch
// PURPOSE
//  Drive-activity LED conditioner between the SGPIO receivers and the DRVn_ACT_LED_CATH_L pins.
//  Takes raw per-drive activity bits, which are active-low and decoded from SGPIO.
//  Stretches each activity burst to a visible minimum on-time and applies a per-drive I2C mask.
//  Optionally blinks LEDs while a drive is active. One instance per SGPIO receiver (36 drives each).
// PARAMETERS
//  N_CH      36     number of drive channels
//  CLK_DIV   25000  SYSCLK cycles per 1 ms tick (25 MHz SYSCLK); must be >= 2
//  HOLD_MS   50     stretch time in ticks after last activity; must be >= 1
//  BLINK_MS  125    blink half-period in ticks (used only with ACT_BLINK_EN)
// PORTS
//  SYSCLK        in   1     system clock
//  RESET_N       in   1     asynchronous reset, active-low
//  ACT_IN        in   N_CH  raw activity from SGPIO; 0 = drive active; treated as asynchronous
//  LED_OFF_MASK  in   N_CH  1 = force channel LED off (I2C GPIO register)
//  ACT_LED_L     out  N_CH  LED cathode drive; 0 = LED lit
//  TICK_1MS      out  1     one-SYSCLK pulse per ms, available to other LED logic
// BEHAVIOUR
//  Clock and reset: single clock SYSCLK; asynchronous active-low reset RESET_N.
//  Reset values: ACT_LED_L all 1, TICK_1MS 0, and all of the following cleared to 0:
//   prescaler, synchronizers, hold counters, blink counter, blink phase.
//  Reset takes effect immediately, including mid-stretch or mid-blink.
//  Prescaler:
//   - Counts 0..CLK_DIV-1 and wraps.
//   - TICK_1MS is registered and is high for exactly one cycle, the cycle after count==CLK_DIV-1.
//  Input sync: 2-FF synchronizer per bit. act[i] = ~sync2[i].
//  Hold counter per channel: width $clog2(HOLD_MS+1).
//   - act[i]=1: load HOLD_MS. This load wins over a simultaneous tick.
//   - else, on tick: decrement if nonzero. Saturates at 0 and never wraps.
//  Channel FSM (derived from counter):
//   - IDLE (cnt==0) -> ACTIVE on load.
//   - ACTIVE -> IDLE when a tick decrements cnt from 1 to 0.
//  Output register: ACT_LED_L[i] = LED_OFF_MASK[i] ? 1 : (ACTIVE ? pattern : 1).
//   - Latency from ACT_IN falling to ACT_LED_L falling is 3 SYSCLK: 2 sync stages + 1 output stage.
//   - Mask changes take effect on ACT_LED_L 1 cycle later.
//   - The mask never stops the counters.
//  Stretch: a single-cycle activity pulse lights the LED for HOLD_MS ticks.
//   - The exact on-time is HOLD_MS or HOLD_MS-1 full tick periods plus a partial tick period.
//   - Retriggering during ACTIVE reloads the counter, so the LED stays lit with no gap.
// CONFIGURATION
//  ACT_BLINK_EN defined:
//   - A shared blink counter counts ticks 0..BLINK_MS-1; its wrap toggles phase. Free-running, so all channels blink in sync.
//   - pattern = phase (phase 0 = lit).
//  ACT_BLINK_EN undefined:
//   - pattern = 0, i.e. the LED is steady lit while ACTIVE.
//   - The blink counter and phase flop are not built.
// STRUCTURE
//  Shared define file (status_define.v) holds:
//   - defaults for ACT_HOLD_MS, ACT_BLINK_MS and SYSCLK_TICK_DIV
//   - the ACT_BLINK_EN switch
//  Sub-module act_led_chan, one per channel via generate. It contains the synchronizer, hold counter and output flop.
//   - Inputs: SYSCLK, RESET_N, ACT_IN bit, tick, mask bit, pattern.
//  Top level of this block holds the prescaler, the blink phase and the generate loop.
//  In TOP it replaces the direct ACT_LED1/ACT_LED2 -> pin assigns.
// TESTING (sim with CLK_DIV=4, HOLD_MS=3, BLINK_MS=2, N_CH=36)
//  1 Reset: RESET_N=0 -> ACT_LED_L all 1 and TICK_1MS=0.
//    Assert RESET_N while ch0 is ACTIVE -> ACT_LED_L[0]=1 in the same cycle; after release the LED stays off until new activity.
//  2 Single stretch: ACT_IN[0]=0 for 1 cycle -> ACT_LED_L[0]=0 on the 3rd edge.
//    It returns to 1 on the 3rd following tick and 1 cycle later. ACT_LED_L[35:1] stay 1 throughout.
//  3 Retrigger: ACT_IN[35] pulsed every 8 cycles (2 ticks) for 100 cycles -> ACT_LED_L[35]=0 continuously; it releases 3 ticks after the last pulse.
//  4 Load vs tick: activity pulse aligned with TICK_1MS while cnt=1 -> counter reads 3, not 2 or 0, and the LED has no off glitch.
//  5 Mask: LED_OFF_MASK[5]=1 with ch5 ACTIVE -> ACT_LED_L[5]=1.
//    Clearing the mask within the hold time -> ACT_LED_L[5]=0 1 cycle later.
//  6 Blink: ACT_IN[7]=0 held low.
//    - With ACT_BLINK_EN: ACT_LED_L[7] alternates, 2 ticks (8 cycles) at 0 and 2 ticks at 1.
//    - Without ACT_BLINK_EN: steady 0.

Source files
------------

// File: rtl/act_led_stretch_pkg.sv
// Shared defaults and helpers for the drive-activity LED conditioner.
// The blink feature is selected at build time with the ACT_BLINK_EN macro.
package act_led_stretch_pkg;

    localparam int ACT_N_CH        = 36;
    localparam int ACT_HOLD_MS     = 50;
    localparam int ACT_BLINK_MS    = 125;
    localparam int SYSCLK_TICK_DIV = 25000;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } chan_state_e;

    // Register width able to hold values 0..n-1, never narrower than one bit.
    function automatic int bits_for(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/act_led_stretch_if.sv
// Pin-side bundle between the SGPIO receiver logic and the LED cathode drivers.
interface act_led_stretch_if #(
    parameter int N_CH = 36
);
    logic [N_CH-1:0] act_in;
    logic [N_CH-1:0] led_off_mask;
    logic [N_CH-1:0] act_led_l;
    logic            tick_1ms;

    modport master (
        output act_in,
        output led_off_mask,
        input  act_led_l,
        input  tick_1ms
    );

    modport slave (
        input  act_in,
        input  led_off_mask,
        output act_led_l,
        output tick_1ms
    );
endinterface

// File: rtl/act_led_chan.sv
// One drive channel: input synchronizer, hold (stretch) counter and registered LED output.
//  state     | meaning
//  CH_IDLE   | hold counter is zero, LED dark
//  CH_ACTIVE | hold counter nonzero, LED shows the blink pattern
module act_led_chan
    import act_led_stretch_pkg::*;
#(
    parameter int HOLD_MS = ACT_HOLD_MS
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic act_in,
    input  logic tick,
    input  logic mask,
    input  logic pattern,
    output logic led_l
);

    localparam int             CW       = bits_for(HOLD_MS + 1);
    localparam logic [CW-1:0]  HOLD_VAL = CW'(HOLD_MS);

    // The synchronizer carries active-high activity, so its cleared state reads as idle.
    logic        sync1_q;
    logic        sync2_q;
    logic        act;
    chan_state_e state_q;
    chan_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic        led_d;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~act_in;
            sync2_q <= sync1_q;
        end
    end

    assign act = sync2_q;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (act) begin
            cnt_d   = HOLD_VAL;
            state_d = CH_ACTIVE;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = CH_IDLE;
            end
        end
        led_d = 1'b1;
        if (!mask && (state_d == CH_ACTIVE)) begin
            led_d = pattern;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            led_l   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_l   <= led_d;
        end
    end

endmodule

// File: rtl/act_led_stretch.sv
// Drive-activity LED conditioner: ms prescaler, shared blink phase and per-channel stretchers.
// Build option: define ACT_BLINK_EN to blink lit LEDs instead of holding them steady.
module act_led_stretch
    import act_led_stretch_pkg::*;
#(
    parameter int N_CH     = ACT_N_CH,
    parameter int CLK_DIV  = SYSCLK_TICK_DIV,
    parameter int HOLD_MS  = ACT_HOLD_MS,
    parameter int BLINK_MS = ACT_BLINK_MS
) (
    input  logic               sysclk,
    input  logic               reset_n,
    act_led_stretch_if.slave   bus
);

    localparam int            PW       = bits_for(CLK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]   pre_q;
    logic            tick_q;
    logic            pattern;
    logic [N_CH-1:0] led_l;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            tick_q <= (pre_q == PRE_LAST);
        end
    end

`ifdef ACT_BLINK_EN
    localparam int            BW         = bits_for(BLINK_MS);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

    logic [BW-1:0] blink_q;
    logic          phase_q;

    // Free-running so every channel blinks in step with the others.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= '0;
            phase_q <= 1'b0;
        end else if (tick_q) begin
            if (blink_q == BLINK_LAST) begin
                blink_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                blink_q <= blink_q + BW'(1);
            end
        end
    end

    assign pattern = phase_q;
`else
    logic unused_blink_ms;
    assign unused_blink_ms = (BLINK_MS > 0);
    assign pattern         = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        act_led_chan #(
            .HOLD_MS (HOLD_MS)
        ) u_chan (
            .sysclk  (sysclk),
            .reset_n (reset_n),
            .act_in  (bus.act_in[i]),
            .tick    (tick_q),
            .mask    (bus.led_off_mask[i]),
            .pattern (pattern),
            .led_l   (led_l[i])
        );
    end

    assign bus.act_led_l = led_l;
    assign bus.tick_1ms  = tick_q;

endmodule
